rc4_decrypt_checker: RTL and testbench

RC4_DECRYPT_CHECKER -- requirements
Module: rc4_decrypt_checker

---
 rtl/rc4_decrypt_checker.sv | 159 +++++++++++++++
 tb/tb_rc4_decrypt_checker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_checker.sv
// RC4 keystream decryptor: one byte per 12-cycle pass over an external S RAM, XORed with a ciphertext ROM.
// Optionally aborts on the first decrypted byte that falls outside the printable character set.
module rc4_decrypt_checker #(
    parameter int         MESSAGE_LENGTH = 32,
    parameter int         ADDR_WIDTH     = 5,
    parameter bit         CHECK_TEXT     = 1'b1,
    parameter logic [7:0] CHAR_LO        = 8'h61,
    parameter logic [7:0] CHAR_HI        = 8'h7A,
    parameter bit         ALLOW_SPACE    = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            s_q,
    input  logic [7:0]            rom_q,
    output logic [7:0]            s_address,
    output logic [7:0]            s_data,
    output logic                  s_wren,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic [ADDR_WIDTH-1:0] decrypt_address,
    output logic [7:0]            decrypt_data,
    output logic                  decrypt_wren,
    output logic                  busy,
    output logic                  finish,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] bad_index
);

    typedef enum logic [3:0] {
        IDLE, INIT, CHECK, INC_I, RD_SI_A, RD_SI_W, CALC_J, RD_SJ_A, RD_SJ_W,
        WR_SI, WR_SJ, RD_F_A, RD_F_W, OUT, DONE
    } state_t;

    // k is one bit wider than the address so a full 2**ADDR_WIDTH message can terminate
    localparam logic [ADDR_WIDTH:0] LEN   = MESSAGE_LENGTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] K_ONE = 1;

    state_t              state;
    state_t              state_next;
    logic [7:0]          i;
    logic [7:0]          j;
    logic [7:0]          si;
    logic [7:0]          sj;
    logic [7:0]          f;
    logic [7:0]          rom_byte;
    logic [ADDR_WIDTH:0] k;
    logic                k_in_range;
    logic                byte_ok;
    logic                abort;

    assign k_in_range      = (k < LEN);
    assign decrypt_data    = f ^ rom_byte;
    assign byte_ok         = ((decrypt_data >= CHAR_LO) && (decrypt_data <= CHAR_HI)) ||
                             (ALLOW_SPACE && (decrypt_data == 8'h20));
    assign abort           = CHECK_TEXT && !byte_ok;
    assign rom_address     = k[ADDR_WIDTH-1:0];
    assign decrypt_address = k[ADDR_WIDTH-1:0];
    assign busy            = (state != IDLE) && (state != DONE);
    assign finish          = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            f         <= '0;
            rom_byte  <= '0;
            pass      <= 1'b0;
            bad_index <= '0;
        end else begin
            state <= state_next;
            case (state)
                INIT: begin
                    i         <= '0;
                    j         <= '0;
                    k         <= '0;
                    pass      <= 1'b0;
                    bad_index <= '0;
                end
                CHECK:   if (!k_in_range) pass <= 1'b1;
                INC_I:   i  <= i + 8'd1;
                RD_SI_W: si <= s_q;
                CALC_J:  j  <= j + si;
                RD_SJ_W: sj <= s_q;
                RD_F_W: begin
                    f        <= s_q;
                    rom_byte <= rom_q;
                end
                OUT: begin
                    k <= k + K_ONE;
                    if (abort) bad_index <= k[ADDR_WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        s_address    = '0;
        s_data       = '0;
        s_wren       = 1'b0;
        decrypt_wren = 1'b0;
        case (state)
            IDLE:    if (start) state_next = INIT;
            INIT:    state_next = CHECK;
            CHECK:   state_next = k_in_range ? INC_I : DONE;
            INC_I:   state_next = RD_SI_A;
            RD_SI_A: begin
                s_address  = i;
                state_next = RD_SI_W;
            end
            RD_SI_W: begin
                s_address  = i;
                state_next = CALC_J;
            end
            CALC_J:  state_next = RD_SJ_A;
            RD_SJ_A: begin
                s_address  = j;
                state_next = RD_SJ_W;
            end
            RD_SJ_W: begin
                s_address  = j;
                state_next = WR_SI;
            end
            // when i == j both latched values are equal, so the two writes agree
            WR_SI: begin
                s_address  = i;
                s_data     = sj;
                s_wren     = 1'b1;
                state_next = WR_SJ;
            end
            WR_SJ: begin
                s_address  = j;
                s_data     = si;
                s_wren     = 1'b1;
                state_next = RD_F_A;
            end
            RD_F_A: begin
                s_address  = si + sj;
                state_next = RD_F_W;
            end
            RD_F_W: begin
                s_address  = si + sj;
                state_next = OUT;
            end
            OUT: begin
                decrypt_wren = 1'b1;
                state_next   = abort ? DONE : CHECK;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_decrypt_checker.sv
// Scoreboard bench: three instances (checked L=4, unchecked L=4, unchecked L=256 with 8-bit addresses).
module tb_rc4_decrypt_checker;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic load_id = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int writes [3] = '{default: 0};
    int fins   [3] = '{default: 0};
    logic [15:0] exp_wr  [3][$];
    logic [8:0]  exp_fin [3][$];
    logic [7:0]  ms [256];

    // instance 0: CHECK_TEXT=1, L=4
    logic       a_start = 1'b0;
    logic [7:0] a_s_q, a_rom_q, a_s_address, a_s_data, a_dec_data;
    logic       a_s_wren, a_dec_wren, a_busy, a_finish, a_pass;
    logic [4:0] a_rom_address, a_dec_address, a_bad;
    logic [7:0] a_s [256];
    logic [7:0] a_rom [32];

    rc4_decrypt_checker #(.MESSAGE_LENGTH(4), .ADDR_WIDTH(5), .CHECK_TEXT(1'b1)) dut_a (
        .clock(clk), .reset(reset), .start(a_start), .s_q(a_s_q), .rom_q(a_rom_q),
        .s_address(a_s_address), .s_data(a_s_data), .s_wren(a_s_wren),
        .rom_address(a_rom_address), .decrypt_address(a_dec_address),
        .decrypt_data(a_dec_data), .decrypt_wren(a_dec_wren), .busy(a_busy),
        .finish(a_finish), .pass(a_pass), .bad_index(a_bad));

    always @(posedge clk) begin
        a_s_q   <= a_s[a_s_address];
        a_rom_q <= a_rom[a_rom_address];
        if (load_id) for (int x = 0; x < 256; x++) a_s[x] <= 8'(x);
        else if (a_s_wren) a_s[a_s_address] <= a_s_data;
    end

    // instance 1: CHECK_TEXT=0, L=256, ADDR_WIDTH=8
    logic       b_start = 1'b0;
    logic [7:0] b_s_q, b_rom_q, b_s_address, b_s_data, b_dec_data;
    logic       b_s_wren, b_dec_wren, b_busy, b_finish, b_pass;
    logic [7:0] b_rom_address, b_dec_address, b_bad;
    logic [7:0] b_s [256];
    logic [7:0] b_rom [256];

    rc4_decrypt_checker #(.MESSAGE_LENGTH(256), .ADDR_WIDTH(8), .CHECK_TEXT(1'b0)) dut_b (
        .clock(clk), .reset(reset), .start(b_start), .s_q(b_s_q), .rom_q(b_rom_q),
        .s_address(b_s_address), .s_data(b_s_data), .s_wren(b_s_wren),
        .rom_address(b_rom_address), .decrypt_address(b_dec_address),
        .decrypt_data(b_dec_data), .decrypt_wren(b_dec_wren), .busy(b_busy),
        .finish(b_finish), .pass(b_pass), .bad_index(b_bad));

    always @(posedge clk) begin
        b_s_q   <= b_s[b_s_address];
        b_rom_q <= b_rom[b_rom_address];
        if (load_id) for (int x = 0; x < 256; x++) b_s[x] <= 8'(x);
        else if (b_s_wren) b_s[b_s_address] <= b_s_data;
    end

    // instance 2: CHECK_TEXT=0, L=4
    logic       c_start = 1'b0;
    logic [7:0] c_s_q, c_rom_q, c_s_address, c_s_data, c_dec_data;
    logic       c_s_wren, c_dec_wren, c_busy, c_finish, c_pass;
    logic [4:0] c_rom_address, c_dec_address, c_bad;
    logic [7:0] c_s [256];
    logic [7:0] c_rom [32];

    rc4_decrypt_checker #(.MESSAGE_LENGTH(4), .ADDR_WIDTH(5), .CHECK_TEXT(1'b0)) dut_c (
        .clock(clk), .reset(reset), .start(c_start), .s_q(c_s_q), .rom_q(c_rom_q),
        .s_address(c_s_address), .s_data(c_s_data), .s_wren(c_s_wren),
        .rom_address(c_rom_address), .decrypt_address(c_dec_address),
        .decrypt_data(c_dec_data), .decrypt_wren(c_dec_wren), .busy(c_busy),
        .finish(c_finish), .pass(c_pass), .bad_index(c_bad));

    always @(posedge clk) begin
        c_s_q   <= c_s[c_s_address];
        c_rom_q <= c_rom[c_rom_address];
        if (load_id) for (int x = 0; x < 256; x++) c_s[x] <= 8'(x);
        else if (c_s_wren) c_s[c_s_address] <= c_s_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int n, input logic sw, input logic dw, input logic [7:0] da,
                       input logic [7:0] dd, input logic fn, input logic ps, input logic [7:0] bi);
        logic [15:0] ew;
        logic [8:0]  ef;
        if (sw || dw) check($sformatf("wren_exclusive_%0d", n), 32'(sw & dw), 32'd0);
        if (dw) begin
            writes[n]++;
            if (exp_wr[n].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write_%0d: actual addr %0h data %0h, required no write", n, da, dd);
            end else begin
                ew = exp_wr[n].pop_front();
                check($sformatf("decrypt_write_%0d", n), 32'({da, dd}), 32'(ew));
            end
        end
        if (fn) begin
            fins[n]++;
            if (exp_fin[n].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_finish_%0d: actual finish, required none", n);
            end else begin
                ef = exp_fin[n].pop_front();
                check($sformatf("finish_pass_bad_%0d", n), 32'({ps, bi}), 32'(ef));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_s_wren, a_dec_wren, 8'(a_dec_address), a_dec_data, a_finish, a_pass, 8'(a_bad));
        mon(1, b_s_wren, b_dec_wren, b_dec_address, b_dec_data, b_finish, b_pass, b_bad);
        mon(2, c_s_wren, c_dec_wren, 8'(c_dec_address), c_dec_data, c_finish, c_pass, 8'(c_bad));
    end

    task automatic set_start(input int n, input logic v);
        case (n)
            0:       a_start = v;
            1:       b_start = v;
            default: c_start = v;
        endcase
    endtask

    function automatic logic fin_of(input int n);
        case (n)
            0:       return a_finish;
            1:       return b_finish;
            default: return c_finish;
        endcase
    endfunction

    // Pulses start; cyc counts negedges after the sampling edge until finish is seen.
    task automatic run(input int n, input int limit, input int busy_at, output int cyc);
        logic f;
        @(negedge clk);
        set_start(n, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            set_start(n, cyc == busy_at);
            f = fin_of(n);
        end while (!f && cyc < limit);
        if (!f) begin
            tests++;
            fails++;
            $display("FAIL finish_timeout_%0d: actual no finish after %0d cycles, required finish", n, limit);
        end
    endtask

    task automatic idle_check_a(input string name);
        check({name, "_data"}, 32'({a_s_address, a_s_data, a_dec_data}), 32'd0);
        check({name, "_ctrl"}, 32'({a_s_wren, a_dec_wren, a_busy, a_finish, a_pass, a_bad,
                                    a_rom_address, a_dec_address}), 32'd0);
    endtask

    task automatic reload_s();
        load_id = 1'b1;
        @(negedge clk);
        load_id = 1'b0;
    endtask

    task automatic push_plain();
        for (int x = 0; x < 4; x++) exp_wr[0].push_back({8'(x), 8'h61});
        exp_fin[0].push_back(9'h100);
    endtask

    initial begin
        int cyc;
        int sw;
        int w0;
        int diffs;
        logic [7:0] mi, mj, t, sum;

        for (int x = 0; x < 32; x++) begin
            a_rom[x] = 8'h00;
            c_rom[x] = 8'h00;
        end
        for (int x = 0; x < 256; x++) b_rom[x] = 8'h00;

        reset   = 1'b1;
        load_id = 1'b1;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        load_id = 1'b0;
        idle_check_a("reset_state");
        check("reset_state_c", 32'({c_busy, c_finish, c_pass, c_bad, c_dec_wren, c_s_wren}), 32'd0);

        // identity S, zero ciphertext, no text checking
        exp_wr[2].push_back(16'h0002);
        exp_wr[2].push_back(16'h0105);
        exp_wr[2].push_back(16'h0207);
        exp_wr[2].push_back(16'h030D);
        exp_fin[2].push_back(9'h100);
        run(2, 200, -1, cyc);
        check("identity_latency", 32'(cyc), 32'd51);
        check("identity_s_2to5", {c_s[2], c_s[3], c_s[4], c_s[5]}, 32'h03050902);
        check("identity_s_9", 32'(c_s[9]), 32'h04);

        // plaintext run
        a_rom[0] = 8'h63; a_rom[1] = 8'h64; a_rom[2] = 8'h66; a_rom[3] = 8'h6C;
        push_plain();
        run(0, 200, -1, cyc);
        check("plain_latency", 32'(cyc), 32'd51);
        check("plain_busy_in_done", 32'(a_busy), 32'd0);

        // abort on byte 2 (0x07)
        reload_s();
        a_rom[2] = 8'h00;
        exp_wr[0].push_back(16'h0061);
        exp_wr[0].push_back(16'h0161);
        exp_wr[0].push_back(16'h0207);
        exp_fin[0].push_back(9'h002);
        w0 = writes[0];
        run(0, 200, -1, cyc);
        check("abort_latency", 32'(cyc), 32'd38);
        check("abort_write_count", 32'(writes[0] - w0), 32'd3);
        @(negedge clk);
        check("abort_held", 32'({a_finish, a_busy, a_pass, a_bad}), 32'h02);

        // reset asserted during WR_SJ of byte 1
        reload_s();
        a_rom[2] = 8'h66;
        exp_wr[0].push_back(16'h0061);
        @(negedge clk);
        a_start = 1'b1;
        cyc = 0;
        sw  = 0;
        do begin
            @(negedge clk);
            a_start = 1'b0;
            cyc++;
            if (a_s_wren) sw++;
        end while (sw < 4 && cyc < 100);
        check("midrun_at_wr_sj", 32'(cyc), 32'd22);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_check_a("midrun_reset");
        reload_s();
        push_plain();
        run(0, 200, -1, cyc);
        check("after_reset_latency", 32'(cyc), 32'd51);

        // 256-byte run: i wraps to 0 on the last byte; start pulsed while busy
        for (int x = 0; x < 256; x++) ms[x] = 8'(x);
        mi = 8'd0;
        mj = 8'd0;
        for (int k = 0; k < 256; k++) begin
            mi     = mi + 8'd1;
            mj     = mj + ms[mi];
            t      = ms[mi];
            ms[mi] = ms[mj];
            ms[mj] = t;
            sum    = ms[mi] + ms[mj];
            exp_wr[1].push_back({8'(k), ms[sum]});
        end
        exp_fin[1].push_back(9'h100);
        run(1, 4000, 100, cyc);
        check("wrap_latency", 32'(cyc), 32'd3075);
        check("wrap_write_count", 32'(writes[1]), 32'd256);
        repeat (20) @(negedge clk);
        check("wrap_single_finish", 32'(fins[1]), 32'd1);
        diffs = 0;
        for (int x = 0; x < 256; x++) if (b_s[x] !== ms[x]) diffs++;
        check("wrap_s_contents", 32'(diffs), 32'd0);

        for (int n = 0; n < 3; n++) begin
            check($sformatf("writes_left_%0d", n), 32'(exp_wr[n].size()), 32'd0);
            check($sformatf("finishes_left_%0d", n), 32'(exp_fin[n].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
